// File: rtl/sar_adc_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC sequencer.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAMP = 2'd1,
        CONV = 2'd2
    } state_t;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sar_adc_ch_next.sv
// Channel-scan helper: finds the next set mask bit above the current index,
// flags a wrap when none remains, and reports the lowest set bit.
module sar_adc_ch_next
    import sar_adc_pkg::*;
#(
    parameter int p_ch_cnt = 4,
    parameter int p_ch_w   = ch_width(p_ch_cnt)
) (
    input  logic [p_ch_cnt-1:0] i_mask,
    input  logic [p_ch_w-1:0]   i_cur,
    output logic [p_ch_w-1:0]   o_next,
    output logic                o_wrap,
    output logic [p_ch_w-1:0]   o_lowest
);

    logic [p_ch_w-1:0] w_lowest;
    logic [p_ch_w-1:0] w_above;
    logic              w_found;

    // Scanning downwards leaves the lowest qualifying index in each result.
    always_comb begin
        w_lowest = '0;
        w_above  = '0;
        w_found  = 1'b0;
        for (int i = p_ch_cnt - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                w_lowest = p_ch_w'(i);
                if (p_ch_w'(i) > i_cur) begin
                    w_above = p_ch_w'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign o_lowest = w_lowest;
    assign o_wrap   = !w_found;
    assign o_next   = w_found ? w_above : w_lowest;

endmodule

// File: rtl/sar_adc_seq.sv
// Multi-channel SAR ADC sequencer: scans a channel mask, runs sample/hold and
// bit-serial successive approximation, and delivers tagged results via valid/ready.
module sar_adc_seq
    import sar_adc_pkg::*;
#(
    parameter int  p_bit_cnt    = 8,
    parameter int  p_ch_cnt     = 4,
    parameter int  p_samp_cyc   = 4,
    parameter int  p_settle_cyc = 2,
    localparam int p_ch_w       = ch_width(p_ch_cnt)
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_cont,
    input  logic [p_ch_cnt-1:0]  i_ch_mask,
    output logic                 o_busy,
    output logic [p_ch_w-1:0]    o_mux_sel,
    output logic                 o_samp,
    output logic [p_bit_cnt-1:0] o_dac,
    input  logic                 i_cmp,
    output logic [p_bit_cnt-1:0] o_res,
    output logic [p_ch_w-1:0]    o_res_ch,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_overrun
);

    localparam int p_cnt_max = (p_samp_cyc > p_settle_cyc) ? p_samp_cyc : p_settle_cyc;
    localparam int p_cnt_w   = ch_width(p_cnt_max);
    localparam logic [p_cnt_w-1:0]   p_samp_last   = p_cnt_w'(p_samp_cyc - 1);
    localparam logic [p_cnt_w-1:0]   p_settle_last = p_cnt_w'(p_settle_cyc - 1);
    localparam logic [p_bit_cnt-1:0] p_msb         = {1'b1, {(p_bit_cnt-1){1'b0}}};

    state_t               r_state;
    state_t               w_state_next;
    logic [p_cnt_w-1:0]   r_cnt;
    logic [p_bit_cnt-1:0] r_cur;
    logic [p_bit_cnt-1:0] r_res;
    logic [p_bit_cnt-1:0] r_res_out;
    logic [p_ch_cnt-1:0]  r_mask;
    logic [p_ch_w-1:0]    r_ch;
    logic [p_ch_w-1:0]    r_res_ch;
    logic                 r_cont;
    logic                 r_stop;
    logic                 r_valid;
    logic                 r_overrun;

    logic [p_ch_cnt-1:0]  w_mask;
    logic [p_ch_w-1:0]    w_next;
    logic [p_ch_w-1:0]    w_lowest;
    logic                 w_wrap;
    logic                 w_go;
    logic                 w_samp_done;
    logic                 w_bit_done;
    logic                 w_conv_done;
    logic                 w_scan_more;
    logic [p_bit_cnt-1:0] w_res_final;

    // In IDLE the lowest-channel search must see the incoming mask, not the stale one.
    assign w_mask = (r_state == IDLE) ? i_ch_mask : r_mask;

    sar_adc_ch_next #(
        .p_ch_cnt (p_ch_cnt),
        .p_ch_w   (p_ch_w)
    ) u_ch_next (
        .i_mask   (w_mask),
        .i_cur    (r_ch),
        .o_next   (w_next),
        .o_wrap   (w_wrap),
        .o_lowest (w_lowest)
    );

    assign w_go        = i_start && (i_ch_mask != '0);
    assign w_samp_done = (r_state == SAMP) && (r_cnt == p_samp_last);
    assign w_bit_done  = (r_state == CONV) && (r_cnt == p_settle_last);
    assign w_conv_done = w_bit_done && r_cur[0];
    assign w_scan_more = !(r_stop || i_stop) && (!w_wrap || r_cont);
    assign w_res_final = i_cmp ? (r_res | r_cur) : r_res;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_go)        w_state_next = SAMP;
            SAMP:    if (w_samp_done) w_state_next = CONV;
            CONV:    if (w_conv_done) w_state_next = w_scan_more ? SAMP : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        o_busy = 1'b0;
        o_samp = 1'b0;
        o_dac  = '0;
        case (r_state)
            SAMP: begin
                o_busy = 1'b1;
                o_samp = 1'b1;
            end
            CONV: begin
                o_busy = 1'b1;
                o_dac  = r_res | r_cur;
            end
            default: ;
        endcase
    end

    // The one counter serves both the sample window and each bit's settle window.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_cur  <= '0;
            r_res  <= '0;
            r_mask <= '0;
            r_ch   <= '0;
            r_cont <= 1'b0;
            r_stop <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_stop <= 1'b0;
                    if (w_go) begin
                        r_mask <= i_ch_mask;
                        r_cont <= i_cont;
                        r_ch   <= w_lowest;
                        r_cnt  <= '0;
                    end
                end
                SAMP: begin
                    if (i_stop) r_stop <= 1'b1;
                    if (w_samp_done) begin
                        r_cnt <= '0;
                        r_cur <= p_msb;
                        r_res <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                CONV: begin
                    if (i_stop) r_stop <= 1'b1;
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        r_res <= w_res_final;
                        r_cur <= r_cur >> 1;
                        if (r_cur[0]) begin
                            if (w_scan_more) begin
                                r_ch <= w_next;
                            end else begin
                                r_stop <= 1'b0;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A write beats a same-edge transfer; overrun only when the old result was never taken.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_res_out <= '0;
            r_res_ch  <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_conv_done) begin
                r_res_out <= w_res_final;
                r_res_ch  <= r_ch;
                r_valid   <= 1'b1;
                r_overrun <= r_valid && !i_ready;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_mux_sel = r_ch;
    assign o_res     = r_res_out;
    assign o_res_ch  = r_res_ch;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_sar_adc_seq.sv
// Randomized bench for sar_adc_seq: an ideal comparator per channel and a
// scan-level model predicting channel order, result timing, codes and handshake.
module tb_sar_adc_seq;

    localparam int S = 4;
    localparam int B = 8;
    localparam int T = 2;
    localparam int P = S + B * T;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       cont  = 1'b0;
    logic       ready = 1'b1;
    logic [3:0] mask  = 4'b0000;
    logic       busy, samp, valid, overrun, cmp;
    logic [1:0] mux_sel, res_ch;
    logic [7:0] dac, res;
    logic [7:0] vin [4];

    assign cmp = (vin[mux_sel] >= dac);

    sar_adc_seq dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .i_stop    (stop),
        .i_cont    (cont),
        .i_ch_mask (mask),
        .o_busy    (busy),
        .o_mux_sel (mux_sel),
        .o_samp    (samp),
        .o_dac     (dac),
        .i_cmp     (cmp),
        .o_res     (res),
        .o_res_ch  (res_ch),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_overrun (overrun)
    );

    logic        start2 = 1'b0;
    logic        ready2 = 1'b0;
    logic        busy2, samp2, valid2, overrun2, cmp2;
    logic [0:0]  mux2, resch2;
    logic [0:0]  mask2 = 1'b1;
    logic [11:0] dac2, res2;
    logic [11:0] vin2 = 12'h000;

    assign cmp2 = (vin2 >= dac2);

    sar_adc_seq #(
        .p_bit_cnt    (12),
        .p_ch_cnt     (1),
        .p_samp_cyc   (4),
        .p_settle_cyc (3)
    ) dut12 (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start2),
        .i_stop    (1'b0),
        .i_cont    (1'b0),
        .i_ch_mask (mask2),
        .o_busy    (busy2),
        .o_mux_sel (mux2),
        .o_samp    (samp2),
        .o_dac     (dac2),
        .i_cmp     (cmp2),
        .o_res     (res2),
        .o_res_ch  (resch2),
        .o_valid   (valid2),
        .i_ready   (ready2),
        .o_overrun (overrun2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // rmode: 0 always ready, 1 never ready, 2 ready only at the final write edge.
    task automatic scan(input logic [3:0] m, input bit c, input int stop_k, input int rmode);
        int chs[$];
        int n, k, ph;
        bit v_exp, ov_exp, rdy, wr;
        n = (stop_k >= 0) ? stop_k + 1 : $countones(m);
        while (chs.size() < n)
            for (int i = 0; i < 4; i++)
                if (m[i] && chs.size() < n) chs.push_back(i);
        v_exp = 1'b0;
        @(negedge clk);
        mask  = m;
        cont  = c;
        start = 1'b1;
        rdy   = (rmode == 0);
        ready = rdy;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 1; e <= n * P + 3; e++) begin
            @(posedge clk);
            wr = (e % P == 0) && (e <= n * P);
            if (wr) begin
                ov_exp = v_exp && !rdy;
                v_exp  = 1'b1;
            end else begin
                ov_exp = 1'b0;
                if (v_exp && rdy) v_exp = 1'b0;
            end
            #1;
            check("valid", valid, v_exp);
            check("overrun", overrun, ov_exp);
            check("busy", busy, e < n * P);
            if (wr) begin
                k = e / P - 1;
                check("res", res, vin[chs[k]]);
                check("res_ch", res_ch, chs[k]);
                $display("t=%0t result ch%0d code %02h", $time, res_ch, res);
            end
            if (e < n * P) begin
                k  = e / P;
                ph = e % P;
                check("mux_sel", mux_sel, chs[k]);
                check("samp", samp, ph < S);
                if (ph < S) check("dac_samp", dac, 0);
            end else begin
                check("dac_idle", dac, 0);
                check("samp_idle", samp, 0);
                check("mux_hold", mux_sel, chs[n-1]);
            end
            stop  = (stop_k >= 0) && (e == stop_k * P + S + 3);
            start = (e == 2);
            mask  = (e == 2) ? 4'hF : m;
            if (e >= n * P)      rdy = 1'b1;
            else if (rmode == 1) rdy = 1'b0;
            else if (rmode == 2) rdy = (e + 1 == n * P);
            else                 rdy = 1'b1;
            ready = rdy;
        end
    endtask

    task automatic scan12(input logic [11:0] val);
        vin2 = val;
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (e == 39) check("v12_early", valid2, 0);
            if (e == 40) begin
                check("v12_valid", valid2, 1);
                check("v12_res", res2, val);
                check("v12_busy", busy2, 0);
                $display("t=%0t result12 code %03h", $time, res2);
            end
        end
        ready2 = 1'b1;
        @(posedge clk);
        #1 ready2 = 1'b0;
        check("v12_drain", valid2, 0);
    endtask

    task automatic rand_vin();
        for (int i = 0; i < 4; i++) vin[i] = 8'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) vin[i] = 8'h00;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_res", res, 0);
        check("rst_mux", mux_sel, 0);
        check("rst_dac", dac, 0);
        check("rst_samp", samp, 0);
        check("rst_ovr", overrun, 0);
        check("rst_valid12", valid2, 0);
        @(negedge clk);
        rst = 1'b0;

        vin[0] = 8'hA5;
        scan(4'b0001, 1'b0, -1, 0);
        vin[1] = 8'h00;
        vin[3] = 8'hFF;
        scan(4'b1010, 1'b0, -1, 0);
        rand_vin();
        scan(4'b0101, 1'b1, 2, 0);
        for (int r = 0; r < 4; r++) begin
            rand_vin();
            scan(4'($urandom_range(1, 15)), 1'b0, -1, 0);
        end
        rand_vin();
        scan(4'($urandom_range(1, 15)), 1'b1, int'($urandom_range(0, 5)), 0);
        rand_vin();
        scan(4'b0011, 1'b0, -1, 1);
        rand_vin();
        scan(4'b0011, 1'b0, -1, 2);

        rand_vin();
        vin[3] = 8'h5A;
        scan(4'b1000, 1'b0, -1, 0);
        @(negedge clk);
        mask  = 4'b0110;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (S + 5) @(posedge clk);
        #1 check("pre_rst_busy", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_samp", samp, 0);
        check("arst_dac", dac, 0);
        check("arst_valid", valid, 0);
        check("arst_res", res, 0);
        check("arst_res_ch", res_ch, 0);
        check("arst_mux", mux_sel, 0);
        check("arst_ovr", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (P + 2) @(posedge clk);
        #1;
        check("post_rst_valid", valid, 0);
        check("post_rst_busy", busy, 0);

        @(negedge clk);
        mask  = 4'b0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 0; e < 3; e++) begin
            check("zero_mask_busy", busy, 0);
            @(posedge clk);
            #1;
        end

        scan12(12'h800);
        scan12(12'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
